exe_stage_mdu: RTL and testbench

Next-generation execute stage for the MIPS pipeline, parametrised in data width.
- Keeps the single-cycle ALU, branch-condition and branch-target paths, and registers their outputs.
- Adds an iterative unsigned multiply/divide unit (MDU) with architectural HI/LO registers and MFHI/MFLO reads.
- Talks to ID/EXE through a valid/ready handshake, so the pipeline stalls while the MDU iterates. Sits between the ID/EXE and EXE/MEM registers.

---
 rtl/exe_pkg.sv | 30 +++
 rtl/exe_stage_mdu_iter.sv | 110 +++++++++++
 rtl/exe_stage_mdu.sv | 106 ++++++++++
 tb/tb_exe_stage_mdu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: EXE_Cmd opcodes, branch types and MDU FSM states.
package exe_pkg;

    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_AND   = 2;
    localparam int ALU_OR    = 3;
    localparam int ALU_NOR   = 4;
    localparam int ALU_XOR   = 5;
    localparam int ALU_SLL   = 6;
    localparam int ALU_SRL   = 7;
    localparam int ALU_SRA   = 8;
    localparam int ALU_SLT   = 9;
    localparam int ALU_SLTU  = 10;
    localparam int MDU_MULTU = 16;
    localparam int MDU_DIVU  = 17;
    localparam int MDU_MFHI  = 18;
    localparam int MDU_MFLO  = 19;

    localparam int BR_NONE = 0;
    localparam int BR_BEQ  = 1;
    localparam int BR_BNE  = 2;
    localparam int BR_JMP  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/exe_stage_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) with architectural HI/LO.
// One radix-2 step per cycle for DATA_W cycles; done marks the edge that loads HI/LO.
module mdu_iter
    import exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] lo_n
);

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    logic [DATA_W-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d, opnd_q, opnd_d;
    logic [DATA_W-1:0] step_hi, step_lo;
    logic [DATA_W:0]   sum, shifted;

    // p_hi/p_lo hold accumulator:multiplier for MULTU and remainder:quotient for DIVU
    always_comb begin
        sum     = {1'b0, p_hi_q} + {1'b0, opnd_q};
        shifted = {p_hi_q, p_lo_q[DATA_W-1]};
        step_hi = p_hi_q;
        step_lo = p_lo_q;
        if (div_q) begin
            if (shifted >= {1'b0, opnd_q}) begin
                step_hi = DATA_W'(shifted - {1'b0, opnd_q});
                step_lo = {p_lo_q[DATA_W-2:0], 1'b1};
            end else begin
                step_hi = shifted[DATA_W-1:0];
                step_lo = {p_lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            if (p_lo_q[0]) begin
                step_hi = sum[DATA_W:1];
                step_lo = {sum[0], p_lo_q[DATA_W-1:1]};
            end else begin
                step_hi = {1'b0, p_hi_q[DATA_W-1:1]};
                step_lo = {p_hi_q[0], p_lo_q[DATA_W-1:1]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        opnd_d  = opnd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(DATA_W);
                    div_d   = op_div;
                    p_hi_d  = '0;
                    p_lo_d  = op_div ? a : b;
                    opnd_d  = op_div ? b : a;
                end
            end
            ST_BUSY: begin
                p_hi_d = step_hi;
                p_lo_d = step_lo;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
    assign lo_n = step_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            opnd_q  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            opnd_q  <= opnd_d;
            if (done) begin
                hi <= step_hi;
                lo <= step_lo;
            end
        end
    end

endmodule

// File: rtl/exe_stage_mdu.sv
// MIPS execute stage: single-cycle ALU and branch resolution plus an iterative MDU.
// ID/EXE handshake stalls (in_ready low) while the MDU iterates.
module exe_stage_mdu
    import exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 5,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        BR_Type,
    input  logic [CMD_W-1:0]  EXE_Cmd,
    input  logic [DATA_W-1:0] readdata1,
    input  logic [DATA_W-1:0] readdata2,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] Immediate,
    input  logic [DATA_W-1:0] PC_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALU_result,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_address,
    output logic              busy
);

    localparam int SH_W = $clog2(DATA_W);

    logic              accept, is_mdu_op, mdu_busy, mdu_done, br_cond;
    logic [DATA_W-1:0] hi, lo, lo_n, alu_res, br_addr;
    logic [SH_W-1:0]   shamt;

    assign in_ready  = !mdu_busy;
    assign busy      = mdu_busy;
    assign accept    = in_valid && in_ready;
    assign is_mdu_op = (EXE_Cmd == CMD_W'(MDU_MULTU)) || (EXE_Cmd == CMD_W'(MDU_DIVU));
    assign shamt     = data2[SH_W-1:0];
    assign br_addr   = PC_in + (Immediate << 2) - DATA_W'(4);

    mdu_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_mdu_op),
        .op_div (EXE_Cmd == CMD_W'(MDU_DIVU)),
        .a      (readdata1),
        .b      (data2),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .hi     (hi),
        .lo     (lo),
        .lo_n   (lo_n)
    );

    always_comb begin
        alu_res = '0;
        case (EXE_Cmd)
            CMD_W'(ALU_ADD):  alu_res = readdata1 + data2;
            CMD_W'(ALU_SUB):  alu_res = readdata1 - data2;
            CMD_W'(ALU_AND):  alu_res = readdata1 & data2;
            CMD_W'(ALU_OR):   alu_res = readdata1 | data2;
            CMD_W'(ALU_NOR):  alu_res = ~(readdata1 | data2);
            CMD_W'(ALU_XOR):  alu_res = readdata1 ^ data2;
            CMD_W'(ALU_SLL):  alu_res = readdata1 << shamt;
            CMD_W'(ALU_SRL):  alu_res = readdata1 >> shamt;
            CMD_W'(ALU_SRA):  alu_res = $unsigned($signed(readdata1) >>> shamt);
            CMD_W'(ALU_SLT):  alu_res = {{(DATA_W-1){1'b0}}, $signed(readdata1) < $signed(data2)};
            CMD_W'(ALU_SLTU): alu_res = {{(DATA_W-1){1'b0}}, readdata1 < data2};
            CMD_W'(MDU_MFHI): alu_res = hi;
            CMD_W'(MDU_MFLO): alu_res = lo;
            default:          alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (BR_Type)
            2'(BR_BEQ): br_cond = (readdata1 == readdata2);
            2'(BR_BNE): br_cond = (readdata1 != readdata2);
            2'(BR_JMP): br_cond = 1'b1;
            default:    br_cond = 1'b0;
        endcase
    end

    // An accepted MDU op updates only the branch outputs; its result appears on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            ALU_result     <= '0;
            branch_taken   <= 1'b0;
            branch_address <= '0;
        end else if (mdu_done) begin
            out_valid      <= 1'b1;
            ALU_result     <= lo_n;
            branch_taken   <= 1'b0;
        end else if (accept) begin
            out_valid      <= !is_mdu_op;
            branch_taken   <= br_cond && !is_mdu_op;
            branch_address <= br_addr;
            if (!is_mdu_op) ALU_result <= alu_res;
        end else begin
            out_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Self-checking bench for exe_stage_mdu against an arithmetic reference model.
module tb_exe_stage_mdu;
    import exe_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, branch_taken, busy;
    logic [1:0]    BR_Type;
    logic [4:0]    EXE_Cmd;
    logic [DW-1:0] readdata1, readdata2, data2, Immediate, PC_in, ALU_result, branch_address;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] m_hi = '0, m_lo = '0;

    exe_stage_mdu #(.DATA_W(DW), .CMD_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .BR_Type(BR_Type), .EXE_Cmd(EXE_Cmd), .readdata1(readdata1),
        .readdata2(readdata2), .data2(data2), .Immediate(Immediate), .PC_in(PC_in),
        .out_valid(out_valid), .ALU_result(ALU_result), .branch_taken(branch_taken),
        .branch_address(branch_address), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_alu(input logic [4:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (int'(cmd))
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_NOR:  return ~(a | b);
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return DW'($signed(a) >>> sh);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLTU: return (a < b) ? 1 : 0;
            MDU_MFHI: return m_hi;
            MDU_MFLO: return m_lo;
            default:  return '0;
        endcase
    endfunction

    function automatic logic exp_taken(input logic [1:0] br, input logic [4:0] cmd, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        if (int'(cmd) == MDU_MULTU || int'(cmd) == MDU_DIVU) return 1'b0;
        case (int'(br))
            BR_BEQ:  return r1 == r2;
            BR_BNE:  return r1 != r2;
            BR_JMP:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Updates the HI/LO model; returns the expected LO.
    function automatic logic [DW-1:0] model_mdu(input logic [4:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        if (int'(cmd) == MDU_MULTU) begin
            p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            m_hi = p[2*DW-1:DW];
            m_lo = p[DW-1:0];
        end else if (b == 0) begin
            m_hi = a;
            m_lo = '1;
        end else begin
            m_hi = a % b;
            m_lo = a / b;
        end
        return m_lo;
    endfunction

    task automatic present(input logic [4:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] r2, input logic [1:0] br, input logic [DW-1:0] imm, input logic [DW-1:0] pc);
        EXE_Cmd = cmd; readdata1 = a; data2 = b; readdata2 = r2;
        BR_Type = br; Immediate = imm; PC_in = pc; in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Single-cycle op: accept, then check all registered outputs in the next cycle.
    task automatic run_single(input string name, input logic [4:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] r2, input logic [1:0] br, input logic [DW-1:0] imm, input logic [DW-1:0] pc);
        logic [DW-1:0] er, ea;
        logic et;
        er = exp_alu(cmd, a, b);
        et = exp_taken(br, cmd, a, r2);
        ea = pc + imm * 4 - 4;
        present(cmd, a, b, r2, br, imm, pc);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready actual=%b required=1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ALU_result !== er || branch_taken !== et || branch_address !== ea) begin
            failures++;
            $display("FAIL %s cmd=%0d actual v=%b r=%h t=%b a=%h required v=1 r=%h t=%b a=%h",
                     name, cmd, out_valid, ALU_result, branch_taken, branch_address, er, et, ea);
        end
    endtask

    // MDU op: accept, then check latency, stall window and result.
    task automatic run_mdu(input string name, input logic [4:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] elo;
        int cyc, low;
        elo = model_mdu(cmd, a, b);
        present(cmd, a, b, '0, 2'(BR_JMP), 32'h10, 32'h100);
        tick();
        in_valid = 1'b0;
        cyc = 1; low = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (in_ready === 1'b0 && busy === 1'b1) low++;
            tick();
            cyc++;
        end
        checks++;
        if (cyc != DW + 1 || low != DW) begin
            failures++;
            $display("FAIL %s_latency actual out_valid_cycle=%0d stall=%0d required %0d/%0d", name, cyc, low, DW + 1, DW);
        end
        checks++;
        if (ALU_result !== elo || branch_taken !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_result actual r=%h t=%b rdy=%b required r=%h t=0 rdy=1", name, ALU_result, branch_taken, in_ready, elo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        present(5'd0, '0, '0, '0, 2'd0, '0, '0);
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 0 || ALU_result !== 0 || branch_taken !== 0 || branch_address !== 0 || busy !== 0 || in_ready !== 1) begin
            failures++;
            $display("FAIL reset actual v=%b r=%h t=%b a=%h busy=%b rdy=%b required zeros rdy=1",
                     out_valid, ALU_result, branch_taken, branch_address, busy, in_ready);
        end
    endtask

    task automatic test_alu();
        logic [4:0] cmd;
        logic [DW-1:0] hold;
        run_single("add_ovf", 5'(ALU_ADD), 32'h7FFF_FFFF, 32'h1, '0, 2'(BR_NONE), '0, 32'h20);
        hold = ALU_result;
        tick();
        checks++;
        if (out_valid !== 1'b0 || ALU_result !== hold) begin
            failures++;
            $display("FAIL idle_hold actual v=%b r=%h required v=0 r=%h", out_valid, ALU_result, hold);
        end
        run_single("sra_neg", 5'(ALU_SRA), 32'h8000_0000, 32'd31, '0, 2'(BR_NONE), '0, 32'h4);
        run_single("slt_signed", 5'(ALU_SLT), 32'hFFFF_FFFF, 32'd1, '0, 2'(BR_NONE), '0, 32'h4);
        run_single("sltu", 5'(ALU_SLTU), 32'hFFFF_FFFF, 32'd1, '0, 2'(BR_NONE), '0, 32'h4);
        run_single("undef_cmd", 5'd13, 32'h1234, 32'h5678, '0, 2'(BR_NONE), '0, 32'h4);
        for (int i = 0; i < 60; i++) begin
            cmd = 5'($urandom_range(0, 29));
            if (cmd == 5'(MDU_MULTU) || cmd == 5'(MDU_DIVU)) cmd = 5'($urandom_range(0, 10));
            run_single("alu_rand", cmd, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
    endtask

    task automatic test_branch();
        logic [DW-1:0] v;
        run_single("beq_taken", 5'(ALU_ADD), 32'd5, 32'd0, 32'd5, 2'(BR_BEQ), 32'd3, 32'h40);
        run_single("bne_not", 5'(ALU_ADD), 32'd5, 32'd0, 32'd5, 2'(BR_BNE), 32'd3, 32'h40);
        run_single("jmp_neg_off", 5'(ALU_OR), 32'd1, 32'd2, 32'd9, 2'(BR_JMP), 32'hFFFF_FFFE, 32'h100);
        for (int i = 0; i < 20; i++) begin
            v = $urandom;
            run_single("br_rand", 5'(ALU_XOR), v, $urandom, (i % 2 == 0) ? v : $urandom,
                       2'($urandom_range(0, 3)), $urandom, $urandom);
        end
    endtask

    task automatic test_mdu();
        run_mdu("multu_max", 5'(MDU_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_single("mfhi", 5'(MDU_MFHI), '0, '0, '0, 2'(BR_NONE), '0, '0);
        run_single("mflo", 5'(MDU_MFLO), '0, '0, '0, 2'(BR_NONE), '0, '0);
        run_mdu("divu_100_7", 5'(MDU_DIVU), 32'd100, 32'd7);
        run_single("mfhi_rem", 5'(MDU_MFHI), '0, '0, '0, 2'(BR_NONE), '0, '0);
        run_mdu("divu_zero", 5'(MDU_DIVU), 32'h1234, 32'd0);
        run_single("mfhi_div0", 5'(MDU_MFHI), '0, '0, '0, 2'(BR_NONE), '0, '0);
        run_mdu("divu_zero_msb", 5'(MDU_DIVU), 32'h8765_4321, 32'd0);
        run_single("mfhi_div0_msb", 5'(MDU_MFHI), '0, '0, '0, 2'(BR_NONE), '0, '0);
        for (int i = 0; i < 8; i++) begin
            run_mdu("mdu_rand", (i % 2 == 0) ? 5'(MDU_MULTU) : 5'(MDU_DIVU), $urandom,
                    (i == 5) ? 32'($urandom_range(1, 300)) : $urandom);
            run_single("mfhi_rand", 5'(MDU_MFHI), '0, '0, '0, 2'(BR_NONE), '0, '0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] da, db, e_div, e_mul, e_add, got[$];
        int idx, seen_at_mul, seen_at_add;
        logic acc_now;
        da = $urandom; db = 32'($urandom_range(1, 1000));
        e_div = model_mdu(5'(MDU_DIVU), da, db);
        present(5'(MDU_DIVU), da, db, '0, 2'(BR_NONE), '0, '0);
        tick();
        e_mul = model_mdu(5'(MDU_MULTU), 32'd6, 32'd7);
        present(5'(MDU_MULTU), 32'd6, 32'd7, '0, 2'(BR_NONE), '0, '0);
        e_add = 32'h1111_0000 + 32'h0000_2222;
        idx = 0; seen_at_mul = -1; seen_at_add = -1;
        for (int c = 0; c < 200 && !(idx == 2 && got.size() >= 3); c++) begin
            acc_now = in_valid && in_ready;
            if (acc_now && idx == 0) seen_at_mul = got.size();
            if (acc_now && idx == 1) seen_at_add = got.size();
            tick();
            if (out_valid === 1'b1) got.push_back(ALU_result);
            if (acc_now) begin
                if (idx == 0) present(5'(ALU_ADD), 32'h1111_0000, 32'h0000_2222, '0, 2'(BR_NONE), '0, '0);
                else in_valid = 1'b0;
                idx++;
            end
        end
        in_valid = 1'b0;
        repeat (3) begin
            tick();
            if (out_valid === 1'b1) got.push_back(ALU_result);
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL b2b_count actual=%0d required=3", got.size());
        end else begin
            checks++;
            if (got[0] !== e_div || got[1] !== e_mul || got[2] !== e_add) begin
                failures++;
                $display("FAIL b2b_order actual %h %h %h required %h %h %h", got[0], got[1], got[2], e_div, e_mul, e_add);
            end
        end
        checks++;
        if (seen_at_mul != 1 || seen_at_add != 2) begin
            failures++;
            $display("FAIL b2b_accept_timing actual mul_after=%0d add_after=%0d required 1/2", seen_at_mul, seen_at_add);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        present(5'(MDU_MULTU), 32'hDEAD_BEEF, 32'h1234_5678, '0, 2'(BR_NONE), '0, '0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid actual busy=%b rdy=%b v=%b required 0/1/0", busy, in_ready, out_valid);
        end
        pulses = 0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_no_pulse actual=%0d required=0", pulses);
        end
        run_single("mflo_after_rst", 5'(MDU_MFLO), '0, '0, '0, 2'(BR_NONE), '0, '0);
        run_single("mfhi_after_rst", 5'(MDU_MFHI), '0, '0, '0, 2'(BR_NONE), '0, '0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mdu();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
